uart_mmio_port: RTL and testbench

//   Device-side end of the simulated UART byte stream. Gives a core a small

---
 rtl/uart_mmio_port.sv | 148 ++++++++++++++
 tb/tb_uart_mmio_port.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_port.sv
// uart_mmio_port: MMIO register window over a TX byte FIFO feeding serial_out_*
// and an RX byte FIFO filled from serial_in_*.
module uart_mmio_port #(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8,
  parameter int ADDR_W   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              serial_out_valid,
  input  logic              serial_out_ready,
  output logic [7:0]        serial_out_bits,
  input  logic              serial_in_valid,
  output logic              serial_in_ready,
  input  logic [7:0]        serial_in_bits,
  output logic              irq
);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [TX_AW:0] TX_FULL_CNT = TX_DEPTH[TX_AW:0];
  localparam logic [RX_AW:0] RX_FULL_CNT = RX_DEPTH[RX_AW:0];

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  logic [1:0] reg_sel;
  logic       wr_txdata, wr_status, wr_ctrl, rd_rxdata;

  assign reg_sel   = req_addr[3:2];
  assign wr_txdata = req_valid &  req_write & (reg_sel == REG_TXDATA);
  assign wr_status = req_valid &  req_write & (reg_sel == REG_STATUS);
  assign wr_ctrl   = req_valid &  req_write & (reg_sel == REG_CTRL);
  assign rd_rxdata = req_valid & ~req_write & (reg_sel == REG_RXDATA);

  logic unused_bits;
  assign unused_bits = ^{req_addr, req_wdata};

  // TX FIFO
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [TX_AW:0]   tx_count;
  logic             tx_full, tx_empty, tx_push, tx_pop, tx_ovf_set;

  assign tx_full    = (tx_count == TX_FULL_CNT);
  assign tx_empty   = (tx_count == '0);
  assign tx_push    = wr_txdata & ~tx_full;
  assign tx_ovf_set = wr_txdata &  tx_full;
  assign tx_pop     = ~tx_empty & serial_out_ready;

  assign serial_out_valid = ~tx_empty;
  assign serial_out_bits  = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr];

  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= req_wdata[7:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
    end
  end

  // RX FIFO; ready is held low while reset is asserted so nothing is captured
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [RX_AW:0]   rx_count;
  logic             rx_full, rx_empty, rx_push, rx_pop;
  logic [7:0]       rx_head;

  assign rx_full         = (rx_count == RX_FULL_CNT);
  assign rx_empty        = (rx_count == '0);
  assign serial_in_ready = ~rx_full & ~reset;
  assign rx_push         = serial_in_valid & serial_in_ready;
  assign rx_pop          = rd_rxdata & ~rx_empty;
  assign rx_head         = rx_mem[rx_rd_ptr];

  always_ff @(posedge clock) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= serial_in_bits;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
    end
  end

  // Register file: read mux, sticky overflow, interrupt enables
  logic        tx_ovf;
  logic [1:0]  ctrl;
  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_RXDATA: if (!rx_empty) rdata = {23'b0, 1'b1, rx_head};
      REG_STATUS: rdata = {8'b0, 8'(tx_count), 8'(rx_count), 3'b0,
                           tx_ovf, rx_full, ~rx_empty, tx_empty, tx_full};
      REG_CTRL:   rdata = {30'b0, ctrl};
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      tx_ovf     <= 1'b0;
      ctrl       <= '0;
      irq        <= 1'b0;
    end else begin
      resp_valid <= req_valid;
      resp_rdata <= (req_valid & ~req_write) ? rdata : '0;
      if (tx_ovf_set)                   tx_ovf <= 1'b1;
      else if (wr_status & req_wdata[4]) tx_ovf <= 1'b0;
      if (wr_ctrl) ctrl <= req_wdata[1:0];
      irq <= (~rx_empty & ctrl[0]) | (tx_empty & ctrl[1]);
    end
  end

endmodule

// File: tb/tb_uart_mmio_port.sv
// tb_uart_mmio_port: register vector table, response and TX byte scoreboards,
// and hand-written sequences for backpressure, overflow, irq and reset.
`timescale 1ns/1ps
module tb_uart_mmio_port;
  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_write;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        serial_out_valid, serial_out_ready;
  logic [7:0]  serial_out_bits;
  logic        serial_in_valid, serial_in_ready;
  logic [7:0]  serial_in_bits;
  logic        irq;

  uart_mmio_port #(.TX_DEPTH(8), .RX_DEPTH(8), .ADDR_W(4)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .serial_out_valid(serial_out_valid), .serial_out_ready(serial_out_ready),
    .serial_out_bits(serial_out_bits),
    .serial_in_valid(serial_in_valid), .serial_in_ready(serial_in_ready),
    .serial_in_bits(serial_in_bits),
    .irq(irq)
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] rdata; int due; } resp_t;
  typedef struct { logic wr; logic [3:0] addr; logic [31:0] wdata; logic [31:0] rdata; } vec_t;

  resp_t      exp_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Call at a negedge; returns at the following negedge.
  task automatic mmio(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp);
    resp_t e;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    e.rdata = exp;
    e.due   = cyc + 1;
    exp_q.push_back(e);
    @(negedge clock);
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic rx_send(input logic [7:0] b);
    @(negedge clock);
    serial_in_valid = 1'b1; serial_in_bits = b;
    #3;
    chk("rx_ready", 64'(serial_in_ready), 64'd1);
    rx_q.push_back(b);
  endtask

  // Response and TX stream monitors, sampled 3ns after each negedge
  resp_t      r;
  logic       tx_hold = 1'b0;
  logic [7:0] tx_hold_bits = '0;
  always begin
    @(negedge clock);
    #3;
    if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
      r = exp_q.pop_front();
      chk("resp_valid", 64'(resp_valid), 64'd1);
      chk("resp_rdata", 64'(resp_rdata), 64'(r.rdata));
    end else if (resp_valid) begin
      chk("resp_unexpected", 64'(resp_valid), 64'd0);
    end
    if (reset) begin
      tx_hold = 1'b0;
    end else begin
      if (tx_hold) begin
        chk("tx_hold_valid", 64'(serial_out_valid), 64'd1);
        chk("tx_hold_bits", 64'(serial_out_bits), 64'(tx_hold_bits));
      end
      if (serial_out_valid && serial_out_ready) begin
        if (tx_q.size() == 0) chk("tx_unexpected", 64'(serial_out_valid), 64'd0);
        else                  chk("tx_byte", 64'(serial_out_bits), 64'(tx_q.pop_front()));
      end
      tx_hold      = serial_out_valid && !serial_out_ready;
      tx_hold_bits = serial_out_bits;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[11];
  int   k;

  initial begin
    vecs[0]  = '{1'b0, 4'h8, 32'h0,        32'h0000_0002};
    vecs[1]  = '{1'b1, 4'hC, 32'hFFFF_FFFF, 32'h0};
    vecs[2]  = '{1'b0, 4'hC, 32'h0,        32'h0000_0003};
    vecs[3]  = '{1'b1, 4'hC, 32'h0,        32'h0};
    vecs[4]  = '{1'b0, 4'hC, 32'h0,        32'h0};
    vecs[5]  = '{1'b0, 4'h0, 32'h0,        32'h0};
    vecs[6]  = '{1'b0, 4'h4, 32'h0,        32'h0};
    vecs[7]  = '{1'b0, 4'h8, 32'h0,        32'h0000_0002};
    vecs[8]  = '{1'b1, 4'h4, 32'h55,       32'h0};
    vecs[9]  = '{1'b0, 4'hB, 32'h0,        32'h0000_0002};
    vecs[10] = '{1'b0, 4'hD, 32'h0,        32'h0};

    reset = 1'b1;
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    serial_out_ready = 0; serial_in_valid = 0; serial_in_bits = '0;
    #3;
    chk("reset_outputs", {resp_valid, resp_rdata, serial_out_valid, serial_out_bits,
                          serial_in_ready, irq}, 64'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    #3;
    chk("ready_after_reset", 64'(serial_in_ready), 64'd1);

    // register vectors, issued back to back
    @(negedge clock);
    for (int i = 0; i < 11; i++) mmio(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata);

    // TX ordering with the consumer stalled, then released
    foreach (vecs[i]) begin end
    for (int i = 0; i < 3; i++) begin
      tx_q.push_back(8'h41 + 8'(i));
      mmio(1, 4'h0, 32'h41 + i, 0);
    end
    #3;
    chk("tx_valid_held", 64'(serial_out_valid), 64'd1);
    chk("tx_bits_held", 64'(serial_out_bits), 64'h41);
    @(negedge clock);
    mmio(0, 4'h8, 0, 32'h0003_0000);
    serial_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clock);
      #3;
      chk("tx_stream_valid", 64'(serial_out_valid), 64'd1);
      chk("tx_stream_bits", 64'(serial_out_bits), 64'h41 + 64'(i));
    end
    @(negedge clock); #3;
    chk("tx_empty_after_stream", 64'(serial_out_valid), 64'd0);
    @(negedge clock);
    serial_out_ready = 1'b0;

    // TX overflow, clear, and overflow while the head drains
    for (int i = 0; i < 8; i++) begin
      tx_q.push_back(8'h80 + 8'(i));
      mmio(1, 4'h0, 32'h80 + i, 0);
    end
    mmio(1, 4'h0, 32'h99, 0);
    mmio(0, 4'h8, 0, 32'h0008_0011);
    mmio(1, 4'h8, 32'h10, 0);
    mmio(0, 4'h8, 0, 32'h0008_0001);
    serial_out_ready = 1'b1;
    mmio(1, 4'h0, 32'h99, 0);
    serial_out_ready = 1'b0;
    mmio(0, 4'h8, 0, 32'h0007_0010);
    mmio(1, 4'h8, 32'h10, 0);
    mmio(0, 4'h8, 0, 32'h0007_0000);
    serial_out_ready = 1'b1;
    k = 0;
    while (serial_out_valid && k < 40) begin
      @(negedge clock);
      k++;
    end
    #3;
    chk("tx_drain", 64'(serial_out_valid), 64'd0);
    @(negedge clock);
    serial_out_ready = 1'b0;

    // RX backpressure: ninth byte waits for a pop
    for (int i = 0; i < 8; i++) rx_send(8'h10 + 8'(i));
    @(negedge clock);
    serial_in_bits = 8'h18;
    #3;
    chk("rx_ready_drop", 64'(serial_in_ready), 64'd0);
    @(negedge clock);
    mmio(0, 4'h4, 0, {23'b0, 1'b1, rx_q.pop_front()});
    #3;
    chk("rx_ready_return", 64'(serial_in_ready), 64'd1);
    rx_q.push_back(8'h18);
    @(negedge clock);
    serial_in_valid = 1'b0;
    mmio(0, 4'h8, 0, 32'h0000_080E);
    for (int i = 0; i < 8; i++) mmio(0, 4'h4, 0, {23'b0, 1'b1, rx_q.pop_front()});
    mmio(0, 4'h4, 0, 32'h0);
    mmio(0, 4'h8, 0, 32'h0000_0002);

    // same-cycle RX push and MMIO pop at count 3
    for (int i = 0; i < 3; i++) rx_send(8'h21 + 8'(i));
    @(negedge clock);
    serial_in_bits = 8'h24;
    mmio(0, 4'h4, 0, {23'b0, 1'b1, rx_q.pop_front()});
    rx_q.push_back(8'h24);
    serial_in_valid = 1'b0;
    mmio(0, 4'h8, 0, 32'h0000_0306);
    for (int i = 0; i < 3; i++) mmio(0, 4'h4, 0, {23'b0, 1'b1, rx_q.pop_front()});

    // irq follows FIFO and CTRL changes one cycle late
    mmio(1, 4'hC, 32'h1, 0);
    #3;
    chk("irq_idle", 64'(irq), 64'd0);
    rx_send(8'h5A);
    @(negedge clock);
    serial_in_valid = 1'b0;
    #3;
    chk("irq_lag", 64'(irq), 64'd0);
    @(negedge clock); #3;
    chk("irq_rx", 64'(irq), 64'd1);
    @(negedge clock);
    mmio(0, 4'h4, 0, {23'b0, 1'b1, rx_q.pop_front()});
    #3;
    chk("irq_pop_lag", 64'(irq), 64'd1);
    @(negedge clock); #3;
    chk("irq_cleared", 64'(irq), 64'd0);
    @(negedge clock);
    mmio(1, 4'hC, 32'h2, 0);
    #3;
    chk("irq_txie_lag", 64'(irq), 64'd0);
    @(negedge clock); #3;
    chk("irq_txie", 64'(irq), 64'd1);

    // asynchronous reset with FIFO contents and a response in flight
    @(negedge clock);
    mmio(1, 4'hC, 32'h3, 0);
    mmio(1, 4'h0, 32'h77, 0);
    serial_in_valid = 1'b1; serial_in_bits = 8'h33;
    @(negedge clock);
    serial_in_valid = 1'b0;
    @(negedge clock); #3;
    chk("irq_pre_reset", 64'(irq), 64'd1);
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'h8;
    @(posedge clock); #1;
    chk("inflight_resp", 64'(resp_valid), 64'd1);
    #1;
    reset = 1'b1;
    req_valid = 1'b0; req_addr = '0;
    serial_in_valid = 1'b1; serial_in_bits = 8'hEE;
    #1;
    chk("async_reset_outputs", {resp_valid, resp_rdata, serial_out_valid, serial_out_bits,
                                serial_in_ready, irq}, 64'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    serial_in_valid = 1'b0;
    #3;
    chk("ready_after_async_reset", 64'(serial_in_ready), 64'd1);
    @(negedge clock);
    mmio(0, 4'h8, 0, 32'h0000_0002);
    mmio(0, 4'hC, 0, 32'h0);
    mmio(0, 4'h4, 0, 32'h0);
    #3;
    chk("irq_after_reset", 64'(irq), 64'd0);
    chk("tx_valid_after_reset", 64'(serial_out_valid), 64'd0);

    @(negedge clock); @(negedge clock); #3;
    chk("resp_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("tx_queue_drained", 64'(tx_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
